// File: rtl/imm_gen_pipe.sv
// Two-stage pipelined RV32I/RV64I immediate generator.
// S1 latches the raw instruction with its opcode class. S2 builds the
// sign-extended immediate. Valid/ready handshakes on both sides, a
// synchronous flush, and a saturating count of delivered illegal opcodes.
module imm_gen_pipe #(
  parameter int XLEN       = 32,  // 32 or 64
  parameter int CNT_W      = 16,
  parameter int SHAMT_ZEXT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [2:0]       fmt,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_count
);

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;

  // Opcode classification; the *W opcodes exist only on RV64.
  function automatic fmt_e decode_fmt(input logic [6:0] op);
    fmt_e f;
    f = FMT_NONE;
    case (op)
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: f = FMT_I;
      OP_STORE:                            f = FMT_S;
      OP_BRANCH:                           f = FMT_B;
      OP_LUI, OP_AUIPC:                    f = FMT_U;
      OP_JAL:                              f = FMT_J;
      OP_REG:                              f = FMT_R;
      OP_IMM32:                            f = (XLEN == 64) ? FMT_I : FMT_NONE;
      OP_REG32:                            f = (XLEN == 64) ? FMT_R : FMT_NONE;
      default:                             f = FMT_NONE;
    endcase
    return f;
  endfunction

  // Shift-immediates (slli/srli/srai) carry a shamt, not a signed value.
  function automatic logic is_shift_imm(input logic [31:0] w);
    return (SHAMT_ZEXT != 0) && (w[6:0] == OP_IMM) && (w[13:12] == 2'b01);
  endfunction

  // Immediate assembly; instr[31] is always the sign bit.
  function automatic logic signed [XLEN-1:0] build_imm(input logic [31:0] w,
                                                       input fmt_e      f);
    logic signed [XLEN-1:0] r;
    r = '0;
    case (f)
      FMT_I: begin
        if (is_shift_imm(w)) begin
          if (XLEN == 64) r = {{(XLEN-6){1'b0}}, w[25:20]};
          else            r = {{(XLEN-5){1'b0}}, w[24:20]};
        end else begin
          r = {{(XLEN-11){w[31]}}, w[30:20]};
        end
      end
      FMT_S:   r = {{(XLEN-11){w[31]}}, w[30:25], w[11:7]};
      FMT_B:   r = {{(XLEN-12){w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
      FMT_U:   r = {{(XLEN-31){w[31]}}, w[30:12], 12'b0};
      FMT_J:   r = {{(XLEN-20){w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic                   vld_p1;
  logic [31:0]            instr_p1;
  fmt_e                   fmt_p1;
  logic                   vld_p2;
  logic signed [XLEN-1:0] imm_p2;
  fmt_e                   fmt_p2;
  logic                   illegal_p2;
  logic [CNT_W-1:0]       cnt;

  logic s2_load;
  logic in_fire;
  logic out_fire;

  assign s2_load  = vld_p1 & (~vld_p2 | out_ready);
  assign in_ready = ~flush & (~vld_p1 | s2_load);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = vld_p2 & out_ready;

  // ---- stage 1: capture instruction and its class ----

  // S1 occupancy: filled by an accepted input, emptied when S2 takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (in_fire) begin
      vld_p1 <= 1'b1;
    end else if (s2_load) begin
      vld_p1 <= 1'b0;
    end
  end

  // S1 payload, loaded only on an input handshake.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      instr_p1 <= instr;
      fmt_p1   <= decode_fmt(instr[6:0]);
    end
  end

  // ---- stage 2: immediate construction and output register ----

  // S2 occupancy: filled from S1, emptied by an output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
    end else if (flush) begin
      vld_p2 <= 1'b0;
    end else if (s2_load) begin
      vld_p2 <= 1'b1;
    end else if (out_fire) begin
      vld_p2 <= 1'b0;
    end
  end

  // S2 payload; these drive the outputs directly, so they have reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_p2     <= '0;
      fmt_p2     <= FMT_NONE;
      illegal_p2 <= 1'b0;
    end else if (s2_load && !flush) begin
      imm_p2     <= build_imm(instr_p1, fmt_p1);
      fmt_p2     <= fmt_p1;
      illegal_p2 <= (fmt_p1 == FMT_NONE);
    end
  end

  // Illegal-delivery counter; flush does not touch it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (out_fire && illegal_p2) begin
      cnt <= sat_inc(cnt);
    end
  end

  assign out_valid     = vld_p2;
  assign imm           = imm_p2;
  assign fmt           = fmt_p2;
  assign illegal       = illegal_p2;
  assign illegal_count = cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomized and directed bench for imm_gen_pipe, run on an RV32 instance
// and an RV64 instance (2-bit counter) sharing the same input stream.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] instr = '0;

  logic        in_ready_a, out_valid_a, illegal_a;
  logic [31:0] imm_a;
  logic [2:0]  fmt_a;
  logic [15:0] cnt_a;

  logic        in_ready_b, out_valid_b, illegal_b;
  logic [63:0] imm_b;
  logic [2:0]  fmt_b;
  logic [1:0]  cnt_b;

  imm_gen_pipe dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready_a), .instr(instr), .out_valid(out_valid_a),
    .out_ready(out_ready), .imm(imm_a), .fmt(fmt_a), .illegal(illegal_a),
    .illegal_count(cnt_a)
  );

  imm_gen_pipe #(.XLEN(64), .CNT_W(2), .SHAMT_ZEXT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready_b), .instr(instr), .out_valid(out_valid_b),
    .out_ready(out_ready), .imm(imm_b), .fmt(fmt_b), .illegal(illegal_b),
    .illegal_count(cnt_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: formats and immediates straight from the ISA rules.
  function automatic logic [2:0] ref_fmt(input logic [31:0] w, input bit rv64);
    case (w[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: return 3'd1;
      7'h23:                      return 3'd2;
      7'h63:                      return 3'd3;
      7'h37, 7'h17:               return 3'd4;
      7'h6F:                      return 3'd5;
      7'h33:                      return 3'd0;
      7'h1B:                      return rv64 ? 3'd1 : 3'd7;
      7'h3B:                      return rv64 ? 3'd0 : 3'd7;
      default:                    return 3'd7;
    endcase
  endfunction

  function automatic longint sx(input logic [31:0] x, input int bits);
    longint t;
    t = longint'({32'b0, x});
    t = t << (64 - bits);
    t = t >>> (64 - bits);
    return t;
  endfunction

  function automatic logic [63:0] ref_imm(input logic [31:0] w, input bit rv64);
    longint v;
    v = 0;
    case (ref_fmt(w, rv64))
      3'd1: begin
        if (w[6:0] == 7'h13 && w[13:12] == 2'b01)
          v = rv64 ? longint'((w >> 20) & 32'h3F) : longint'((w >> 20) & 32'h1F);
        else
          v = sx({20'b0, w[31:20]}, 12);
      end
      3'd2: v = sx({20'b0, w[31:25], w[11:7]}, 12);
      3'd3: v = sx({19'b0, w[31], w[7], w[30:25], w[11:8], 1'b0}, 13);
      3'd4: v = sx(w & 32'hFFFFF000, 32);
      3'd5: v = sx({11'b0, w[31], w[19:12], w[20], w[30:21], 1'b0}, 21);
      default: v = 0;
    endcase
    return v;
  endfunction

  logic [31:0] q[$];
  int unsigned exp_cnt_a = 0;
  int unsigned exp_cnt_b = 0;
  int          acc = 0;
  int          cyc = 0;

  always @(negedge rst_n) begin
    q.delete();
    exp_cnt_a = 0;
    exp_cnt_b = 0;
  end

  // Input side of the scoreboard: record accepted words, drop on flush.
  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
      if (in_valid && in_ready_a) begin
        q.push_back(instr);
        acc++;
      end
      if (flush) q.delete();
    end
  end

  // Output side: every valid result must match the oldest accepted word.
  always @(negedge clk) begin
    logic [31:0] w;
    if (rst_n) begin
      chk("cnt32", 64'(cnt_a), 64'(exp_cnt_a));
      chk("cnt64", 64'(cnt_b), 64'(exp_cnt_b));
      if (out_valid_a || out_valid_b) begin
        if (q.size() == 0) begin
          chk("spurious_out", {62'b0, out_valid_a, out_valid_b}, 64'd0);
        end else begin
          w = q[0];
          chk("vld32", 64'(out_valid_a), 64'd1);
          chk("vld64", 64'(out_valid_b), 64'd1);
          chk("imm32", 64'(imm_a), {32'b0, ref_imm(w, 1'b0) & 64'hFFFFFFFF});
          chk("fmt32", 64'(fmt_a), 64'(ref_fmt(w, 1'b0)));
          chk("ill32", 64'(illegal_a), 64'(ref_fmt(w, 1'b0) == 3'd7));
          chk("imm64", imm_b, ref_imm(w, 1'b1));
          chk("fmt64", 64'(fmt_b), 64'(ref_fmt(w, 1'b1)));
          chk("ill64", 64'(illegal_b), 64'(ref_fmt(w, 1'b1) == 3'd7));
          if (out_ready) begin
            void'(q.pop_front());
            if (ref_fmt(w, 1'b0) == 3'd7 && exp_cnt_a < 65535) exp_cnt_a++;
            if (ref_fmt(w, 1'b1) == 3'd7 && exp_cnt_b < 3) exp_cnt_b++;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input int budget);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    instr = w;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = in_ready_a;
      step();
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain(input int budget);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < budget && q.size() != 0; i++) step();
    step();
    chk("drain_left", 64'(q.size()), 64'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  ops [13];
    ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37,
            7'h17, 7'h6F, 7'h33, 7'h1B, 7'h3B, 7'h7F};
    r = $urandom();
    if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 12)];
    return r;
  endfunction

  logic [31:0] st_w   [5] = '{32'hFE112E23, 32'hFE000CE3, 32'h123450B7, 32'hFFDFF06F, 32'h01F09093};
  logic [63:0] st_e64 [5] = '{64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8, 64'h0000000012345000,
                              64'hFFFFFFFFFFFFFFFC, 64'h000000000000001F};
  logic [2:0]  st_f   [5] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd1};
  logic [31:0] bp_w   [4] = '{32'h00A00513, 32'h00B12023, 32'h000010B7, 32'h008000EF};

  initial begin
    int c0, a0, k;
    logic [31:0] held;
    logic [15:0] snap_a;
    logic [1:0]  snap_b;

    // Reset values
    repeat (2) @(posedge clk);
    #2;
    chk("rst_vld", 64'(out_valid_a), 64'd0);
    chk("rst_imm", 64'(imm_a), 64'd0);
    chk("rst_fmt", 64'(fmt_a), 64'd7);
    chk("rst_ill", 64'(illegal_a), 64'd0);
    chk("rst_cnt", 64'(cnt_a), 64'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rdy", 64'(in_ready_a), 64'd1);
    chk("rst_imm64", imm_b, 64'd0);
    step();

    // addi x1,x0,-1 with latency check
    in_valid = 1'b1;
    instr = 32'hFFF00093;
    @(negedge clk);
    chk("addi_rdy", 64'(in_ready_a), 64'd1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("addi_lat1", 64'(out_valid_a), 64'd0);
    step();
    @(negedge clk);
    chk("addi_lat2", 64'(out_valid_a), 64'd1);
    chk("addi_imm32", 64'(imm_a), 64'hFFFFFFFF);
    chk("addi_imm64", imm_b, 64'hFFFFFFFFFFFFFFFF);
    chk("addi_fmt", 64'(fmt_a), 64'd1);
    drain(10);

    // Back-to-back stream
    c0 = cyc;
    k = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(st_w[i], 4);
      end
      begin
        for (int c = 0; c < 20 && k < 5; c++) begin
          @(negedge clk);
          if (out_valid_a) begin
            chk("stream_imm32", 64'(imm_a), st_e64[k] & 64'hFFFFFFFF);
            chk("stream_imm64", imm_b, st_e64[k]);
            chk("stream_fmt", 64'(fmt_a), 64'(st_f[k]));
            k++;
          end
        end
      end
    join
    chk("stream_count", 64'(k), 64'd5);
    drain(10);

    // Backpressure: two accepts, then stall with held output
    out_ready = 1'b0;
    a0 = acc;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      instr = bp_w[acc - a0];
      @(negedge clk);
      chk("bp_rdy", 64'(in_ready_a), (i < 2) ? 64'd1 : 64'd0);
      step();
    end
    chk("bp_acc", 64'(acc - a0), 64'd2);
    @(negedge clk);
    held = imm_a;
    step();
    step();
    @(negedge clk);
    chk("bp_vld", 64'(out_valid_a), 64'd1);
    chk("bp_hold", 64'(imm_a), 64'(held));
    step();
    out_ready = 1'b1;
    send(bp_w[2], 6);
    send(bp_w[3], 6);
    drain(10);

    // Illegal path and counter saturation
    send(32'h0000007F, 4);
    @(negedge clk);
    step();
    @(negedge clk);
    chk("ill_vld", 64'(out_valid_a), 64'd1);
    chk("ill_fmt", 64'(fmt_a), 64'd7);
    chk("ill_flag", 64'(illegal_a), 64'd1);
    chk("ill_imm", 64'(imm_a), 64'd0);
    drain(10);
    chk("ill_cnt1", 64'(cnt_a), 64'd1);
    send(32'h1234567F, 4);
    send(32'hFFFFFFFF, 4);
    send(32'h0000000B, 4);
    send(32'h8000005B, 4);
    drain(10);
    chk("ill_cnt5", 64'(cnt_a), 64'd5);
    chk("ill_sat", 64'(cnt_b), 64'd3);

    // Flush with both stages full and an input offered
    out_ready = 1'b0;
    send(32'h0000007F, 4);
    send(32'h0000107F, 4);
    snap_a = cnt_a;
    snap_b = cnt_b;
    in_valid = 1'b1;
    instr = 32'h00100093;
    flush = 1'b1;
    @(negedge clk);
    chk("fl_rdy", 64'(in_ready_a), 64'd0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("fl_vld32", 64'(out_valid_a), 64'd0);
    chk("fl_vld64", 64'(out_valid_b), 64'd0);
    repeat (4) step();
    chk("fl_cnt32", 64'(cnt_a), 64'(snap_a));
    chk("fl_cnt64", 64'(cnt_b), 64'(snap_b));

    // Asynchronous reset mid-stream
    send(32'h0FF00093, 4);
    send(32'h0000007F, 4);
    in_valid = 1'b1;
    instr = 32'hABCDE037;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_vld", 64'(out_valid_a), 64'd0);
    chk("arst_imm", 64'(imm_a), 64'd0);
    chk("arst_fmt", 64'(fmt_a), 64'd7);
    chk("arst_cnt", 64'(cnt_a), 64'd0);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    in_valid = 1'b1;
    instr = 32'hABCDE037;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("arst_lat1", 64'(out_valid_a), 64'd0);
    step();
    @(negedge clk);
    chk("arst_lat2", 64'(out_valid_a), 64'd1);
    chk("arst_imm32", 64'(imm_a), 64'hABCDE000);
    chk("arst_imm64", imm_b, 64'hFFFFFFFFABCDE000);
    drain(10);

    // Random traffic with backpressure and occasional flush
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      instr     = rand_instr();
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      step();
    end
    flush = 1'b0;
    drain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
